// File: rtl/atm_pkg.sv
// Shared types and constants for the cash dispenser: controller states,
// note denomination codes, error codes and denomination arithmetic helpers.
package atm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLAN,
      DISPENSE,
      DONE,
      ERROR
   } state_t;

   localparam logic [1:0] DENOM_10  = 2'd0;
   localparam logic [1:0] DENOM_20  = 2'd1;
   localparam logic [1:0] DENOM_50  = 2'd2;
   localparam logic [1:0] DENOM_100 = 2'd3;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_NOT_MULT = 2'd1;
   localparam logic [1:0] ERR_NO_NOTES = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   function automatic logic [9:0] denom_value(input logic [1:0] d);
      case (d)
         DENOM_100: return 10'd100;
         DENOM_50:  return 10'd50;
         DENOM_20:  return 10'd20;
         default:   return 10'd10;
      endcase
   endfunction

   // Constant divisors per denomination keep the planner free of a generic divider.
   function automatic logic [9:0] notes_needed(input logic [9:0] amount, input logic [1:0] d);
      case (d)
         DENOM_100: return amount / 10'd100;
         DENOM_50:  return amount / 10'd50;
         DENOM_20:  return amount / 10'd20;
         default:   return amount / 10'd10;
      endcase
   endfunction

endpackage

// File: rtl/cash_dispenser_if.sv
// Request/slot signal bundle between the ATM controller (master) and the dispenser (slave).
interface cash_dispenser_if;

   logic       cash_valid;
   logic [9:0] cash_amount;
   logic       note_taken;
   logic       refill;
   logic       busy;
   logic       note_valid;
   logic [1:0] note_denom;
   logic       dispense_done;
   logic       dispense_error;
   logic [1:0] err_code;
   logic [9:0] dispensed_amount;
   logic [31:0] notes_left;

   modport master (
      output cash_valid, cash_amount, note_taken, refill,
      input  busy, note_valid, note_denom, dispense_done, dispense_error,
             err_code, dispensed_amount, notes_left
   );

   modport slave (
      input  cash_valid, cash_amount, note_taken, refill,
      output busy, note_valid, note_denom, dispense_done, dispense_error,
             err_code, dispensed_amount, notes_left
   );

endinterface

// File: rtl/note_inventory.sv
// Four 8-bit note counters (index = denomination code) with a bulk refill
// load and a single-note decrement per cycle.
module note_inventory
   import atm_pkg::*;
#(
   parameter int INIT_NOTES = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        dec_en,
   input  logic [1:0]  dec_denom,
   output logic [31:0] counts
);

   logic [3:0][7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         for (int i = 0; i < 4; i++) count_d[i] = 8'(INIT_NOTES);
      end else if (dec_en) begin
         count_d[dec_denom] = count_q[dec_denom] - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= {4{8'(INIT_NOTES)}};
      else     count_q <= count_d;
   end

   assign counts = count_q;

endmodule

// File: rtl/cash_dispenser.sv
// Cash dispenser controller: plans a payout largest-denomination-first, then
// presents notes one at a time until all are collected or one times out.
module cash_dispenser
   import atm_pkg::*;
#(
   parameter int INIT_NOTES  = 20,
   parameter int TIMEOUT_CYC = 1000
) (
   input logic             clk,
   input logic             rst,
   cash_dispenser_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t          state_q, state_d;
   logic [9:0]      rem_q, rem_d;
   logic [3:0][7:0] plan_q, plan_d;
   logic [1:0]      idx_q, idx_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            note_valid_q, note_valid_d;
   logic [1:0]      denom_q, denom_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [9:0]      paid_q, paid_d;
   logic            busy_q;

   logic [31:0]     inv_flat;
   logic [3:0][7:0] inv;
   logic            inv_load, inv_dec;
   logic [9:0]      quota;
   logic [7:0]      planned;

   note_inventory #(.INIT_NOTES(INIT_NOTES)) u_inventory (
      .clk       (clk),
      .rst       (rst),
      .load      (inv_load),
      .dec_en    (inv_dec),
      .dec_denom (denom_q),
      .counts    (inv_flat)
   );

   assign inv     = inv_flat;
   assign quota   = notes_needed(rem_q, idx_q);
   assign planned = ({2'b00, inv[idx_q]} < quota) ? inv[idx_q] : quota[7:0];

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      plan_d       = plan_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      note_valid_d = note_valid_q;
      denom_d      = denom_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      err_code_d   = err_code_q;
      paid_d       = paid_q;
      inv_load     = 1'b0;
      inv_dec      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.refill) begin
               inv_load = 1'b1;
            end else if (bus.cash_valid && bus.cash_amount != 10'd0) begin
               rem_d      = bus.cash_amount;
               paid_d     = 10'd0;
               plan_d     = '0;
               idx_d      = DENOM_100;
               err_code_d = ERR_NONE;
               if (bus.cash_amount % 10'd10 != 10'd0) begin
                  state_d    = ERROR;
                  error_d    = 1'b1;
                  err_code_d = ERR_NOT_MULT;
               end else begin
                  state_d = PLAN;
               end
            end
         end

         PLAN: begin
            plan_d[idx_q] = planned;
            rem_d = rem_q - ({2'b00, planned} * denom_value(idx_q));
            if (idx_q == DENOM_10) begin
               // Any leftover means the payout cannot be made exactly; nothing is issued.
               if (rem_d != 10'd0) begin
                  state_d    = ERROR;
                  error_d    = 1'b1;
                  err_code_d = ERR_NO_NOTES;
               end else begin
                  state_d = DISPENSE;
               end
            end else begin
               idx_d = idx_q - 2'd1;
            end
         end

         DISPENSE: begin
            if (!note_valid_q) begin
               for (int i = 0; i < 4; i++) begin
                  if (plan_q[i] != 8'd0) denom_d = 2'(i);
               end
               note_valid_d = 1'b1;
               timer_d      = '0;
            end else if (bus.note_taken) begin
               inv_dec         = 1'b1;
               plan_d[denom_q] = plan_q[denom_q] - 8'd1;
               paid_d          = paid_q + denom_value(denom_q);
               note_valid_d    = 1'b0;
               if (plan_d == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               // Uncollected note is retracted into the reject bin, so it leaves inventory.
               inv_dec      = 1'b1;
               note_valid_d = 1'b0;
               plan_d       = '0;
               state_d      = ERROR;
               error_d      = 1'b1;
               err_code_d   = ERR_TIMEOUT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         plan_q       <= '0;
         idx_q        <= '0;
         timer_q      <= '0;
         note_valid_q <= 1'b0;
         denom_q      <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_code_q   <= ERR_NONE;
         paid_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         plan_q       <= plan_d;
         idx_q        <= idx_d;
         timer_q      <= timer_d;
         note_valid_q <= note_valid_d;
         denom_q      <= denom_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_code_q   <= err_code_d;
         paid_q       <= paid_d;
         busy_q       <= (state_d != IDLE);
      end
   end

   assign bus.busy             = busy_q;
   assign bus.note_valid       = note_valid_q;
   assign bus.note_denom       = denom_q;
   assign bus.dispense_done    = done_q;
   assign bus.dispense_error   = error_q;
   assign bus.err_code         = err_code_q;
   assign bus.dispensed_amount = paid_q;
   assign bus.notes_left       = inv_flat;

endmodule

// File: tb/tb_cash_dispenser.sv
// Scoreboard bench: two dispensers (20 and 2 notes per denomination); stimulus
// queues expected note/done/error events, a monitor pops and compares them.
module tb_cash_dispenser;

   localparam int EV_NOTE = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int          dut;
      int          kind;
      logic [1:0]  code;
      logic [9:0]  amount;
      logic [31:0] left;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_r;
   logic [1:0]       cash_valid_r;
   logic [1:0][9:0]  cash_amount_r;
   logic [1:0]       note_taken_r;
   logic [1:0]       refill_r;

   logic [1:0]       busy_w, note_valid_w, done_w, err_w;
   logic [1:0][1:0]  denom_w, code_w;
   logic [1:0][9:0]  amt_w;
   logic [1:0][31:0] left_w;

   exp_t exp_q[$];
   int   compared;
   int   failed;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      cash_dispenser_if bus();
      assign bus.cash_valid  = cash_valid_r[g];
      assign bus.cash_amount = cash_amount_r[g];
      assign bus.note_taken  = note_taken_r[g];
      assign bus.refill      = refill_r[g];
      assign busy_w[g]       = bus.busy;
      assign note_valid_w[g] = bus.note_valid;
      assign denom_w[g]      = bus.note_denom;
      assign done_w[g]       = bus.dispense_done;
      assign err_w[g]        = bus.dispense_error;
      assign code_w[g]       = bus.err_code;
      assign amt_w[g]        = bus.dispensed_amount;
      assign left_w[g]       = bus.notes_left;

      cash_dispenser #(.INIT_NOTES(g == 0 ? 20 : 2), .TIMEOUT_CYC(1000)) dut (
         .clk (clk),
         .rst (rst_r[g]),
         .bus (bus)
      );
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic push_expect(input int d, input int kind, input logic [1:0] code,
                              input logic [9:0] amount, input logic [31:0] left);
      exp_t e;
      e.dut    = d;
      e.kind   = kind;
      e.code   = code;
      e.amount = amount;
      e.left   = left;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int g, input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         checkOutput("event_dut", 32'(g), 32'(e.dut));
         checkOutput("event_kind", 32'(kind), 32'(e.kind));
         if (kind == EV_NOTE) begin
            checkOutput("note_denom", 32'(denom_w[g]), 32'(e.code));
         end else begin
            checkOutput(kind == EV_DONE ? "done_amount" : "error_amount", 32'(amt_w[g]), 32'(e.amount));
            checkOutput("event_notes_left", left_w[g], e.left);
            if (kind == EV_ERR) checkOutput("err_code", 32'(code_w[g]), 32'(e.code));
         end
      end
   endtask

   // Monitor: a note event is the rising edge of note_valid; done/error are single-cycle pulses.
   initial begin
      logic [1:0] nv_prev;
      nv_prev = 2'b00;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (note_valid_w[g] === 1'b1 && nv_prev[g] !== 1'b1) observe(g, EV_NOTE);
            if (done_w[g] === 1'b1) observe(g, EV_DONE);
            if (err_w[g] === 1'b1) observe(g, EV_ERR);
            nv_prev[g] = note_valid_w[g];
         end
      end
   end

   task automatic applyStimulus(input int d, input logic [9:0] amt, input logic cv, input logic rf);
      @(negedge clk);
      cash_valid_r[d]  = cv;
      cash_amount_r[d] = amt;
      refill_r[d]      = rf;
      @(negedge clk);
      cash_valid_r[d] = 1'b0;
      refill_r[d]     = 1'b0;
   endtask

   task automatic wait_note(input int d, input int bound);
      bit found = 1'b0;
      for (int c = 0; c < bound && !found; c++) begin
         if (note_valid_w[d]) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("note_wait_bound", 32'(found), 32'd1);
   endtask

   task automatic wait_outcome(input int d, input int bound);
      bit found = 1'b0;
      for (int c = 0; c < bound && !found; c++) begin
         if (done_w[d] || err_w[d]) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("outcome_wait_bound", 32'(found), 32'd1);
   endtask

   task automatic serve_notes(input int d, input int hold);
      bit finished = 1'b0;
      for (int c = 0; c < 4000 && !finished; c++) begin
         if (done_w[d] || err_w[d]) begin
            finished = 1'b1;
         end else if (note_valid_w[d]) begin
            repeat (hold) @(negedge clk);
            note_taken_r[d] = 1'b1;
            @(negedge clk);
            note_taken_r[d] = 1'b0;
            if (done_w[d] || err_w[d]) finished = 1'b1;
         end
         if (!finished) @(negedge clk);
      end
      checkOutput("serve_bound", 32'(finished), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared      = 0;
      failed        = 0;
      rst_r         = 2'b11;
      cash_valid_r  = '0;
      cash_amount_r = '0;
      note_taken_r  = '0;
      refill_r      = '0;
      repeat (3) @(negedge clk);
      rst_r = 2'b00;

      for (int g = 0; g < 2; g++) begin
         checkOutput("reset_busy", 32'(busy_w[g]), 32'd0);
         checkOutput("reset_note_valid", 32'(note_valid_w[g]), 32'd0);
         checkOutput("reset_done", 32'(done_w[g]), 32'd0);
         checkOutput("reset_error", 32'(err_w[g]), 32'd0);
         checkOutput("reset_err_code", 32'(code_w[g]), 32'd0);
         checkOutput("reset_amount", 32'(amt_w[g]), 32'd0);
         checkOutput("reset_notes_left", left_w[g], g == 0 ? 32'h1414_1414 : 32'h0202_0202);
      end

      // 180 = 100+50+20+10; refill and a new request poked mid-dispense must be ignored.
      push_expect(0, EV_NOTE, 2'd3, 10'd0, 32'd0);
      push_expect(0, EV_NOTE, 2'd2, 10'd0, 32'd0);
      push_expect(0, EV_NOTE, 2'd1, 10'd0, 32'd0);
      push_expect(0, EV_NOTE, 2'd0, 10'd0, 32'd0);
      push_expect(0, EV_DONE, 2'd0, 10'd180, 32'h1313_1313);
      applyStimulus(0, 10'd180, 1'b1, 1'b0);
      wait_note(0, 20);
      checkOutput("busy_in_dispense", 32'(busy_w[0]), 32'd1);
      cash_valid_r[0]  = 1'b1;
      cash_amount_r[0] = 10'd50;
      refill_r[0]      = 1'b1;
      @(negedge clk);
      cash_valid_r[0] = 1'b0;
      refill_r[0]     = 1'b0;
      serve_notes(0, 0);
      @(negedge clk);
      checkOutput("idle_after_done", 32'(busy_w[0]), 32'd0);
      checkOutput("amount_holds", 32'(amt_w[0]), 32'd180);

      applyStimulus(0, 10'd0, 1'b0, 1'b1);
      checkOutput("refill_counts", left_w[0], 32'h1414_1414);

      applyStimulus(0, 10'd30, 1'b1, 1'b1);
      checkOutput("refill_wins_busy", 32'(busy_w[0]), 32'd0);

      applyStimulus(0, 10'd0, 1'b1, 1'b0);
      checkOutput("zero_amount_ignored", 32'(busy_w[0]), 32'd0);

      push_expect(0, EV_ERR, 2'd1, 10'd0, 32'h1414_1414);
      applyStimulus(0, 10'd75, 1'b1, 1'b0);
      wait_outcome(0, 10);
      repeat (3) @(negedge clk);
      checkOutput("err_code_holds", 32'(code_w[0]), 32'd1);
      checkOutput("idle_after_error", 32'(busy_w[0]), 32'd0);

      push_expect(0, EV_NOTE, 2'd3, 10'd0, 32'd0);
      push_expect(0, EV_ERR, 2'd3, 10'd0, 32'h1314_1414);
      applyStimulus(0, 10'd200, 1'b1, 1'b0);
      wait_outcome(0, 1100);

      push_expect(0, EV_NOTE, 2'd3, 10'd0, 32'd0);
      applyStimulus(0, 10'd100, 1'b1, 1'b0);
      wait_note(0, 20);
      rst_r[0] = 1'b1;
      @(negedge clk);
      rst_r[0] = 1'b0;
      checkOutput("midrst_busy", 32'(busy_w[0]), 32'd0);
      checkOutput("midrst_note_valid", 32'(note_valid_w[0]), 32'd0);
      checkOutput("midrst_notes_left", left_w[0], 32'h1414_1414);
      checkOutput("midrst_err_code", 32'(code_w[0]), 32'd0);

      // 1020 = 10x100 + 1x20, exercising several notes of one denomination.
      for (int i = 0; i < 10; i++) push_expect(0, EV_NOTE, 2'd3, 10'd0, 32'd0);
      push_expect(0, EV_NOTE, 2'd1, 10'd0, 32'd0);
      push_expect(0, EV_DONE, 2'd0, 10'd1020, 32'h0A14_1314);
      applyStimulus(0, 10'd1020, 1'b1, 1'b0);
      serve_notes(0, 1);

      push_expect(1, EV_ERR, 2'd2, 10'd0, 32'h0202_0202);
      applyStimulus(1, 10'd500, 1'b1, 1'b0);
      wait_outcome(1, 20);

      push_expect(1, EV_NOTE, 2'd3, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd3, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd2, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd2, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd1, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd1, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd0, 10'd0, 32'd0);
      push_expect(1, EV_NOTE, 2'd0, 10'd0, 32'd0);
      push_expect(1, EV_DONE, 2'd0, 10'd360, 32'h0000_0000);
      applyStimulus(1, 10'd360, 1'b1, 1'b0);
      serve_notes(1, 0);

      push_expect(1, EV_ERR, 2'd2, 10'd0, 32'h0000_0000);
      applyStimulus(1, 10'd10, 1'b1, 1'b0);
      wait_outcome(1, 20);

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/cash_dispenser.md
CASH_DISPENSER -- requirements
Module: cash_dispenser

Interface
REQ-001 Parameter INIT_NOTES, 20, notes per denomination loaded at reset and on refill (8-bit range, 1..255).
REQ-002 Parameter TIMEOUT_CYC, 1000, cycles a presented note may wait for collection before retraction.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cash_valid  input  1  dispense request strobe from ATM controller path.
REQ-006 cash_amount  input  10  requested cash, units of 1.
REQ-007 note_taken  input  1  customer collected the presented note.
REQ-008 refill  input  1  operator refill strobe.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 note_valid  output  1  a note is presented at the slot.
REQ-011 note_denom  output  2  denomination of presented note: 3=100, 2=50, 1=20, 0=10.
REQ-012 dispense_done  output  1  one-cycle pulse, request fully paid.
REQ-013 dispense_error  output  1  one-cycle pulse, request failed.
REQ-014 err_code  output  2  1=not multiple of 10, 2=insufficient notes, 3=collection timeout; valid with dispense_error.
REQ-015 dispensed_amount  output  10  total value collected for the current/last request.
REQ-016 notes_left  output  32  four 8-bit inventory counts, [31:24]=100 ... [7:0]=10.

Function
REQ-017 States: IDLE, PLAN, DISPENSE, DONE, ERROR.
REQ-018 IDLE: cash_valid with nonzero cash_amount accepted; amount latched, dispensed_amount cleared; cash_valid with zero amount ignored.
REQ-019 Accepted amount not a multiple of 10: next state ERROR, err_code=1, no notes planned.
REQ-020 PLAN: exactly 4 cycles, one denomination per cycle, 100 first; planned_n = min(inventory, remaining / value); remaining -= planned_n*value.
REQ-021 After PLAN, remaining != 0: ERROR, err_code=2, inventory untouched (atomic, no partial payout).
REQ-022 Otherwise DISPENSE: notes issued largest denomination first, one note at a time.
REQ-023 note_valid/note_denom held stable until note_taken; on note_taken cycle: inventory of that denom -1, planned count -1, dispensed_amount += value.
REQ-024 Next note presented no earlier than the cycle after note_taken; note_taken while note_valid low ignored.
REQ-025 Last planned note taken: DONE for one cycle (dispense_done=1), then IDLE.
REQ-026 Timeout counter restarts for each presented note; reaching TIMEOUT_CYC without note_taken: note retracted (inventory -1, dispensed_amount unchanged), remaining plan cancelled, ERROR, err_code=3.
REQ-027 ERROR lasts one cycle (dispense_error=1), then IDLE; err_code holds until next accepted request.
REQ-028 refill honoured only in IDLE: all four counts := INIT_NOTES next cycle; refill and cash_valid together in IDLE: refill wins, request dropped.
REQ-029 cash_valid and refill while busy ignored; inventory never wraps below 0 (guaranteed by planning).

Reset
REQ-030 rst: state IDLE, all counts INIT_NOTES, plan/remaining/timer cleared, all outputs 0 except notes_left.
REQ-031 rst mid-operation aborts immediately; presented note discarded with no inventory change, no done/error pulse.

Structure
REQ-032 Shared package atm_pkg holds the state enum, denomination code constants, denomination-value function, err_code constants.
REQ-033 One sub-module, note_inventory: four 8-bit counters with refill load and per-denom decrement.

Verification
REQ-034 Reset, cash 180 -> notes 3,2,1,0 taken one cycle each; dispense_done, dispensed_amount=180, each count 19.
REQ-035 cash 75 -> dispense_error with err_code=1 two cycles after accept, note_valid never high.
REQ-036 INIT_NOTES=2, cash 500 -> plan totals 360, err_code=2 after PLAN, all counts stay 2.
REQ-037 cash 200, first note not taken for TIMEOUT_CYC cycles -> err_code=3, dispensed_amount=0, count100=INIT_NOTES-1.
REQ-038 refill and cash_valid pulsed during DISPENSE ignored; refill in IDLE after 180 payout restores all counts to 20.
REQ-039 rst asserted with note_valid high -> next cycle IDLE, counts INIT_NOTES, no pulses.
